// File: rtl/sync_pkg.sv
// Shared types for the sequencer / detector trigger path: shot FSM states and
// the default detector pulse width.
package sync_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIRING     = 2'd1,
        WAIT_READY = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int DEFAULT_PULSE_WIDTH = 50;

endpackage

// File: rtl/detector_trigger_fanout_trig_channel.sv
// One detector trigger channel: counts down the latched delay, then drives a
// fixed-width pulse and raises done on the edge the pulse falls.
module trig_channel
    import sync_pkg::*;
#(
    parameter int DW          = 20,
    parameter int PULSE_WIDTH = DEFAULT_PULSE_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] delay,
    output logic          pulse,
    output logic          done
);

    localparam int PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH - 1);

    logic            delaying_q, delaying_d;
    logic            pulse_q, pulse_d;
    logic            done_q, done_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [PW_W-1:0] pw_q, pw_d;

    // A down-counter reaching zero costs no extra state, so D = all-ones is safe.
    always_comb begin
        delaying_d = delaying_q;
        pulse_d    = pulse_q;
        done_d     = done_q;
        dly_d      = dly_q;
        pw_d       = pw_q;
        if (start) begin
            delaying_d = 1'b1;
            pulse_d    = 1'b0;
            done_d     = 1'b0;
            dly_d      = delay;
        end else if (delaying_q) begin
            if (dly_q == '0) begin
                delaying_d = 1'b0;
                pulse_d    = 1'b1;
                pw_d       = PW_LAST;
            end else begin
                dly_d = dly_q - 1'b1;
            end
        end else if (pulse_q) begin
            if (pw_q == '0) begin
                pulse_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                pw_d = pw_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            delaying_q <= 1'b0;
            pulse_q    <= 1'b0;
            done_q     <= 1'b0;
            dly_q      <= '0;
            pw_q       <= '0;
        end else begin
            delaying_q <= delaying_d;
            pulse_q    <= pulse_d;
            done_q     <= done_d;
            dly_q      <= dly_d;
            pw_q       <= pw_d;
        end
    end

    assign pulse = pulse_q;
    assign done  = done_q;

endmodule

// File: rtl/detector_trigger_fanout.sv
// Fans the sequencer trigger out to N_CH delayed detector pulses and returns
// detector_ready once all enabled detectors are idle. Optional: TRIG_COUNT_EN.
module detector_trigger_fanout
    import sync_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DW            = 20,
    parameter int PULSE_WIDTH   = DEFAULT_PULSE_WIDTH,
    parameter int READY_TIMEOUT = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trigger_in,
    input  logic [N_CH-1:0]  ch_enable,
    input  logic [N_CH*DW-1:0] ch_delay,
    input  logic [N_CH-1:0]  det_busy,
    output logic [N_CH-1:0]  det_trigger,
    output logic             detector_ready,
    output logic             timeout_flag,
    output logic             armed
`ifdef TRIG_COUNT_EN
    ,
    output logic [31:0]      trig_count
`endif
);

    localparam int WC_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(READY_TIMEOUT - 1);

    state_t          state_q;
    logic            trig_q;
    logic [N_CH-1:0] en_q;
    logic [WC_W-1:0] wait_cnt_q;
    logic            ready_q;
    logic            timeout_q;
    logic            armed_q;

    logic            accept;
    logic [N_CH-1:0] start_w;
    logic [N_CH-1:0] pulse_w;
    logic [N_CH-1:0] done_w;
    logic            all_done;
    logic            busy_clear;

    assign accept     = (state_q == IDLE) && trigger_in && !trig_q;
    assign start_w    = accept ? ch_enable : '0;
    assign all_done   = &(done_w | ~en_q);
    assign busy_clear = ((det_busy & en_q) == '0);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            trig_channel #(
                .DW          (DW),
                .PULSE_WIDTH (PULSE_WIDTH)
            ) u_ch (
                .clock (clock),
                .reset (reset),
                .start (start_w[gi]),
                .delay (ch_delay[gi*DW +: DW]),
                .pulse (pulse_w[gi]),
                .done  (done_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            en_q       <= '0;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            trig_q <= trigger_in;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= FIRING;
                        en_q      <= ch_enable;
                        timeout_q <= 1'b0;
                        armed_q   <= 1'b0;
                    end
                end
                FIRING: begin
                    if (all_done) begin
                        state_q    <= WAIT_READY;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT_READY: begin
                    // A detector going idle on the last allowed cycle is not a timeout.
                    if (busy_clear) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!trigger_in) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        armed_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign det_trigger    = pulse_w;
    assign detector_ready = ready_q;
    assign timeout_flag   = timeout_q;
    assign armed          = armed_q;

`ifdef TRIG_COUNT_EN
    logic [31:0] trig_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_count_q <= '0;
        end else if (accept) begin
            trig_count_q <= trig_count_q + 32'd1;
        end
    end

    assign trig_count = trig_count_q;
`endif

endmodule
